// File: rtl/stepper_seq.sv
// stepper_seq
//   Four-coil stepper-motor sequencer. Produces wave, full-step or half-step
//   coil patterns at a programmable step period. Supports counted moves that
//   end with a completion pulse, and continuous moves that run until stopped.
//   Tracks a signed absolute step position that wraps in two's complement.
//
// Ports
//   clk      : system clock
//   rst      : synchronous, active-high reset
//   enable   : 1 = coils driven and motion allowed, 0 = coils off and motion paused
//   dir      : 1 = forward, 0 = reverse (latched at start)
//   mode     : 00 wave, 01 full-step, 1x half-step (latched at start)
//   period   : clk cycles per step, 0 behaves as 1 (latched at start)
//   steps    : steps in the move, 0 = continuous (latched at start)
//   start    : single-cycle move request
//   stop     : abort the current move
//   salida   : coil drive pattern
//   clk_s    : one-cycle step strobe
//   busy     : move in progress
//   done     : one-cycle pulse when a counted move completes
//   position : signed step position
module stepper_seq #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 16,
  parameter int POS_W = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    dir,
  input  logic [1:0]              mode,
  input  logic [DIV_W-1:0]        period,
  input  logic [CNT_W-1:0]        steps,
  input  logic                    start,
  input  logic                    stop,
  output logic [3:0]              salida,
  output logic                    clk_s,
  output logic                    busy,
  output logic                    done,
  output logic signed [POS_W-1:0] position
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

  state_t           state_q;
  state_t           state_d;
  logic [2:0]       idx_q;
  logic [2:0]       idx_d;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] period_l;
  logic [DIV_W-1:0] last_div;
  logic [CNT_W-1:0] remain_q;
  logic             dir_l;
  logic [1:0]       mode_l;
  logic             counted_l;
  logic             start_ok;
  logic             tick;
  logic             finish;

  // Coil pattern for each of the eight half-step phases.
  function automatic logic [3:0] phase_pattern(input logic [2:0] i);
    logic [3:0] p;
    case (i)
      3'd0:    p = 4'b1000;
      3'd1:    p = 4'b1100;
      3'd2:    p = 4'b0100;
      3'd3:    p = 4'b0110;
      3'd4:    p = 4'b0010;
      3'd5:    p = 4'b0011;
      3'd6:    p = 4'b0001;
      default: p = 4'b1001;
    endcase
    return p;
  endfunction

  // Half-step always advances by one phase. Wave (even phases) and full-step
  // (odd phases) advance by two, except that a single phase is taken when the
  // current index sits on the wrong parity, so the first step lands on a
  // phase that belongs to the selected mode.
  function automatic logic [2:0] step_delta(input logic [1:0] m,
                                            input logic [2:0] i);
    logic [2:0] d;
    if (m[1])
      d = 3'd1;
    else if (i[0] != m[0])
      d = 3'd1;
    else
      d = 3'd2;
    return d;
  endfunction

  // Modulo-8 wrap falls out of the 3-bit arithmetic.
  function automatic logic [2:0] next_idx(input logic [2:0] i,
                                          input logic [1:0] m,
                                          input logic       fwd);
    logic [2:0] n;
    if (fwd)
      n = i + step_delta(m, i);
    else
      n = i - step_delta(m, i);
    return n;
  endfunction

  // Stage p0: divider compare, tick qualification and next-state decode.
  always_comb begin
    state_d  = state_q;
    last_div = (period_l == '0) ? '0 : period_l - DIV_W'(1);
    // The lagging busy flag keeps a start from being accepted in the cycle
    // right after a counted move finishes, while busy is still high.
    start_ok = (state_q == IDLE) && start && enable && !busy;
    // stop outranks a tick falling on the same edge.
    tick     = (state_q == RUN) && enable && !stop && (div_q == last_div);
    finish   = tick && counted_l && (remain_q == CNT_W'(1));
    idx_d    = tick ? next_idx(idx_q, mode_l, dir_l) : idx_q;

    case (state_q)
      IDLE: if (start_ok) state_d = RUN;
      RUN:  if (stop || finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: state, phase and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= 3'd0;
      salida   <= 4'b0000;
      clk_s    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      position <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      salida  <= enable ? phase_pattern(idx_d) : 4'b0000;
      clk_s   <= tick;
      done    <= finish;
      // busy rises one cycle after start and, on a counted finish, falls one
      // cycle after done; an abort drops it on the stop edge itself.
      busy    <= (state_q == RUN) && !stop;
      if (tick)
        position <= dir_l ? position + POS_ONE : position - POS_ONE;
    end
  end

  // Move parameters, step divider and remaining-step count.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      dir_l     <= dir;
      mode_l    <= mode;
      period_l  <= period;
      remain_q  <= steps;
      counted_l <= (steps != '0);
      div_q     <= '0;
    end else if ((state_q == RUN) && enable) begin
      div_q <= tick ? '0 : div_q + DIV_W'(1);
      if (tick && counted_l)
        remain_q <= remain_q - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_stepper_seq.sv
module tb_stepper_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        dir;
  logic [1:0]  mode;
  logic [15:0] period;
  logic [15:0] steps;
  logic        start;
  logic        stop;

  logic [3:0]         salida;
  logic               clk_s;
  logic               busy;
  logic               done;
  logic signed [23:0] position;

  logic [3:0]        salida2;
  logic              clk_s2;
  logic              busy2;
  logic              done2;
  logic signed [3:0] position2;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] exp_fs [4];

  stepper_seq #(.DIV_W(16), .CNT_W(16), .POS_W(24)) dut (
    .clk(clk), .rst(rst), .enable(enable), .dir(dir), .mode(mode),
    .period(period), .steps(steps), .start(start), .stop(stop),
    .salida(salida), .clk_s(clk_s), .busy(busy), .done(done),
    .position(position)
  );

  stepper_seq #(.DIV_W(16), .CNT_W(16), .POS_W(4)) dut_small (
    .clk(clk), .rst(rst), .enable(enable), .dir(dir), .mode(mode),
    .period(period), .steps(steps), .start(start), .stop(stop),
    .salida(salida2), .clk_s(clk_s2), .busy(busy2), .done(done2),
    .position(position2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    exp_fs = '{4'b1001, 4'b0011, 4'b0110, 4'b1100};
    rst = 1'b1; enable = 1'b0; dir = 1'b0; mode = 2'b00;
    period = 16'd0; steps = 16'd0; start = 1'b0; stop = 1'b0;
    repeat (3) step();
    check("rst_salida", salida, 4'b0000);
    check("rst_clk_s", clk_s, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pos", position, 0);

    // Counted half-step move, period 4, three steps.
    rst = 1'b0; enable = 1'b1; mode = 2'b10; dir = 1'b1;
    period = 16'd4; steps = 16'd3;
    step();
    check("idle_hold_salida", salida, 4'b1000);
    check("idle_busy", busy, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t1_busy_start_edge", busy, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      step();
      check("t1_clk_s", clk_s, (k % 4) == 0);
      check("t1_busy", busy, 1'b1);
      check("t1_done", done, k == 12);
      if (k == 4)  check("t1_salida_1", salida, 4'b1100);
      if (k == 8)  check("t1_salida_2", salida, 4'b0100);
      if (k == 12) check("t1_salida_3", salida, 4'b0110);
    end
    step();
    check("t1_busy_after", busy, 1'b0);
    check("t1_done_after", done, 1'b0);
    check("t1_pos", position, 3);

    // Full-step reverse from idx 0, period 1, four steps.
    rst = 1'b1;
    step();
    rst = 1'b0; mode = 2'b01; dir = 1'b0; steps = 16'd4; period = 16'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t2_salida", salida, exp_fs[k]);
      check("t2_clk_s", clk_s, 1'b1);
      check("t2_done", done, k == 3);
    end
    check("t2_pos", position, -4);
    step();
    check("t2_busy_after", busy, 1'b0);
    check("t2_clk_s_after", clk_s, 1'b0);

    // period 0 behaves as period 1; full-step forward from idx 1.
    mode = 2'b01; dir = 1'b1; steps = 16'd2; period = 16'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("t3_clk_s_1", clk_s, 1'b1);
    check("t3_salida_1", salida, 4'b0110);
    step();
    check("t3_clk_s_2", clk_s, 1'b1);
    check("t3_salida_2", salida, 4'b0011);
    check("t3_done", done, 1'b1);
    check("t3_pos", position, -2);
    step();
    check("t3_busy_after", busy, 1'b0);

    // Continuous half-step, period 2, stopped after 10 strobes.
    rst = 1'b1;
    step();
    rst = 1'b0; mode = 2'b10; dir = 1'b1; period = 16'd2; steps = 16'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      check("t4_clk_s_gap", clk_s, 1'b0);
      check("t4_done_gap", done, 1'b0);
      step();
      check("t4_clk_s", clk_s, 1'b1);
      check("t4_done", done, 1'b0);
      if (k == 7) check("t4_salida_idx7", salida, 4'b1001);
      if (k == 8) check("t4_salida_wrap", salida, 4'b1000);
    end
    check("t4_pos", position, 10);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t4_busy_stop", busy, 1'b0);
    check("t4_done_stop", done, 1'b0);
    check("t4_clk_s_stop", clk_s, 1'b0);
    check("t4_pos_stop", position, 10);
    check("t4_salida_hold", salida, 4'b0100);

    // stop on the same edge as a tick.
    period = 16'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("t5_busy", busy, 1'b1);
    step();
    check("t5_clk_s_pre", clk_s, 1'b0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t5_clk_s", clk_s, 1'b0);
    check("t5_pos", position, 10);
    check("t5_busy", busy, 1'b0);
    check("t5_salida", salida, 4'b0100);
    step();
    check("t5_clk_s_after", clk_s, 1'b0);

    // Pause for 7 cycles mid-count with period 5.
    period = 16'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    check("t6_clk_s_early", clk_s, 1'b0);
    step();
    check("t6_clk_s_1", clk_s, 1'b1);
    check("t6_salida_1", salida, 4'b0110);
    check("t6_pos_1", position, 11);
    step();
    step();
    enable = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      check("t6_pause_salida", salida, 4'b0000);
      check("t6_pause_clk_s", clk_s, 1'b0);
      check("t6_pause_busy", busy, 1'b1);
    end
    enable = 1'b1;
    step();
    check("t6_resume_clk_s", clk_s, 1'b0);
    check("t6_resume_salida", salida, 4'b0110);
    step();
    check("t6_resume_clk_s_2", clk_s, 1'b0);
    step();
    check("t6_clk_s_2", clk_s, 1'b1);
    check("t6_salida_2", salida, 4'b0010);
    check("t6_pos_2", position, 12);

    // Reset in the middle of a move.
    rst = 1'b1;
    step();
    check("t7_salida", salida, 4'b0000);
    check("t7_clk_s", clk_s, 1'b0);
    check("t7_busy", busy, 1'b0);
    check("t7_done", done, 1'b0);
    check("t7_pos", position, 0);
    rst = 1'b0;

    // start while disabled is ignored.
    enable = 1'b0; steps = 16'd2; period = 16'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    check("t8_busy", busy, 1'b0);
    check("t8_clk_s", clk_s, 1'b0);
    check("t8_pos", position, 0);
    check("t8_salida", salida, 4'b0000);

    // Position wrap on the 4-bit instance.
    enable = 1'b1; mode = 2'b10; dir = 1'b1; period = 16'd1; steps = 16'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    check("t9_pos_small_max", position2, 7);
    step();
    check("t9_pos_small_wrap", position2, -8);
    check("t9_pos_wide", position, 8);
    check("t9_salida", salida, 4'b1000);
    check("t9_salida_small", salida2, 4'b1000);
    check("t9_busy_small", busy2, 1'b1);
    check("t9_clk_s_small", clk_s2, 1'b1);
    check("t9_done_small", done2, 1'b0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t9_busy_stop", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stepper_seq.md
# stepper_seq

Parametrised stepper-motor sequencer for the four-coil user-project controller. It generates wave, full-step or half-step coil patterns at a programmable step period. It runs either a counted move with a completion pulse or continuous motion until stopped, and it tracks a signed absolute position. It sits inside the user project wrapper, driven by the Wishbone clock and reset. Its coil and step outputs go to user IO pads.

## Interface
Parameters:
- DIV_W, 16, width of step-period register (clk cycles per step)
- CNT_W, 16, width of step-count register
- POS_W, 24, width of signed position counter

Ports:
- clk  in  1  system clock (wb_clk_i at the wrapper)
- rst  in  1  synchronous, active-high reset
- enable  in  1  1 = coils driven and motion allowed; 0 = coils off, motion paused
- dir  in  1  1 = forward (phase index up, position +1); 0 = reverse; latched at start
- mode  in  2  00 wave, 01 full-step, 10 half-step, 11 = half-step; latched at start
- period  in  DIV_W  clk cycles between steps; 0 treated as 1; latched at start
- steps  in  CNT_W  number of steps in the move; 0 = continuous; latched at start
- start  in  1  single-cycle request to begin a move
- stop  in  1  abort current move
- salida  out  4  coil drive pattern
- clk_s  out  1  one-cycle step strobe, high on each step
- busy  out  1  move in progress
- done  out  1  one-cycle pulse on completion of a counted move
- position  out  POS_W  signed step position, two's-complement wrap

## Operation
- All outputs are registered. Reset values: salida=0000, clk_s=0, busy=0, done=0, position=0. Internal phase index idx=0, state IDLE.
- Phase table, idx 0..7 → salida[3:0]: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
  - Wave mode uses the even idx values.
  - Full-step mode uses the odd idx values.
  - Half-step mode uses all eight.
- Step delta:
  - 1 in half-step mode.
  - 1 in wave or full-step mode when idx parity mismatches the mode (wave needs even, full needs odd). This aligns the first step.
  - Otherwise 2.
  - idx wraps modulo 8 in both directions.
- salida = table[idx] when enable=1, else 0000. This holds torque in IDLE while enabled.
- States:
  - IDLE: start=1 and enable=1 latches dir, mode, period, steps. It clears the divider and goes to RUN; busy=1 from the next cycle. start with enable=0 is ignored.
  - RUN, enable=1: the divider counts up to period-1, then issues a tick and restarts. Each tick does the following on one edge: idx += ±delta, position ±1, clk_s=1, salida updated, remaining−1 (counted mode only).
  - RUN, enable=0: the divider is frozen, no ticks occur, busy stays 1, salida=0000. Counting resumes from the frozen value when enable returns.
  - Counted move ends on the tick that makes remaining 0. That same cycle asserts clk_s=1 and done=1; busy=0 and state=IDLE from the following cycle.
  - stop=1 in RUN goes to IDLE on the next edge with no tick, no done, and position kept. stop has priority over a coincident tick.
- start while busy is ignored. stop in IDLE has no effect.
- rst at any time, including mid-move, forces all reset values on the next edge.

## Timing
- start sampled at edge T → busy=1 at T+1. The first clk_s is at cycle T+max(period,1); subsequent clk_s pulses follow every max(period,1) cycles.
- clk_s, salida, position and done change on the same edge. Latency from tick to outputs is 0 extra cycles.
- Inputs other than start, stop and enable are don't-care during RUN.
- Back-to-back move: start may be asserted in the first IDLE cycle after busy falls.

## Test plan
- Reset, enable=1, mode=10, dir=1, period=4, steps=3, start at cycle 10:
  - clk_s at cycles 14, 18, 22.
  - salida 1100, 0100, 0110 on those cycles.
  - done=1 at cycle 22; busy=0 from cycle 23; position=3.
- Starting from idx=0, full-step, dir=0, steps=4, period=1:
  - salida sequence 1001, 0011, 0110, 1100 on consecutive cycles.
  - Final position=−4.
- Continuous move (steps=0), period=2: after 10 strobes assert stop → busy=0 next cycle, done never asserted, position=10, salida holds last pattern.
- Pause during RUN with period=5: drop enable for 7 cycles mid-count → salida=0000 and no clk_s during the pause. The step resumes with the remaining divider count, so the interval between strobes is 12 cycles.
- Edge cases:
  - period=0 behaves as period=1.
  - stop in the same cycle as a tick → no strobe and position unchanged.
  - rst mid-move → all outputs 0 on the next cycle.
  - start with enable=0 → no move.
- Wrap test:
  - Preload position near 2^(POS_W−1)−1 via a forward continuous run with POS_W=4 → position wraps from 7 to −8.
  - idx wraps from 7 to 0 in half-step mode.
